// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer
// Purpose: accepts one ALU request at a time, decodes funct into the controls of
// an external combinational N-bit ALU, holds operands stable for SETTLE cycles,
// captures the ALU outputs and presents a response held until consumed.
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   req_valid/req_ready             request handshake (ready only in IDLE)
//   req_funct, req_a, req_b         operation code and operands
//   alu_in1, alu_in2                operands to the ALU (0 outside EXEC)
//   alu_ainvert, alu_bnegate, alu_op  ALU controls (0 outside EXEC)
//   alu_result, alu_overflow, alu_zero  combinational ALU outputs
//   rsp_valid/rsp_ready             response handshake
//   rsp_result, rsp_overflow, rsp_zero, rsp_err  captured response fields
// Configuration:
//   ALU_SEQ_OVF_TRAP_EN  when defined, ADD/SUB overflow reports rsp_err=1 and a
//                        zero result (rsp_overflow still 1).
module alu_op_sequencer #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned SETTLE = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [3:0]       req_funct,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    output logic [WIDTH-1:0] alu_in1,
    output logic [WIDTH-1:0] alu_in2,
    output logic             alu_ainvert,
    output logic             alu_bnegate,
    output logic [1:0]       alu_op,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_overflow,
    input  logic             alu_zero,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_overflow,
    output logic             rsp_zero,
    output logic             rsp_err
);

    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
    logic [3:0]         r_funct, w_funct_nxt;
    logic [WIDTH-1:0]   r_alu_in1, w_alu_in1_nxt;
    logic [WIDTH-1:0]   r_alu_in2, w_alu_in2_nxt;
    logic               r_ainvert, w_ainvert_nxt;
    logic               r_bnegate, w_bnegate_nxt;
    logic [1:0]         r_op, w_op_nxt;
    logic               r_req_ready, w_req_ready_nxt;
    logic               r_rsp_valid, w_rsp_valid_nxt;
    logic [WIDTH-1:0]   r_rsp_result, w_rsp_result_nxt;
    logic               r_rsp_ovf, w_rsp_ovf_nxt;
    logic               r_rsp_zero, w_rsp_zero_nxt;
    logic               r_rsp_err, w_rsp_err_nxt;

    logic               w_req_legal;
    logic               w_is_addsub;
    logic               w_ovf;

    // Legal operation codes: AND, OR, ADD, SUB, SLT, NOR
    always_comb begin
        w_req_legal = 1'b0;
        case (req_funct)
            4'b0000, 4'b0001, 4'b0010,
            4'b0110, 4'b0111, 4'b1100: w_req_legal = 1'b1;
            default:                   w_req_legal = 1'b0;
        endcase
    end

    // Overflow is only meaningful for the adder operations
    assign w_is_addsub = (r_funct == 4'b0010) || (r_funct == 4'b0110);
    assign w_ovf       = w_is_addsub & alu_overflow;

    // State register and all registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_funct      <= '0;
            r_alu_in1    <= '0;
            r_alu_in2    <= '0;
            r_ainvert    <= 1'b0;
            r_bnegate    <= 1'b0;
            r_op         <= '0;
            r_req_ready  <= 1'b1;
            r_rsp_valid  <= 1'b0;
            r_rsp_result <= '0;
            r_rsp_ovf    <= 1'b0;
            r_rsp_zero   <= 1'b0;
            r_rsp_err    <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_funct      <= w_funct_nxt;
            r_alu_in1    <= w_alu_in1_nxt;
            r_alu_in2    <= w_alu_in2_nxt;
            r_ainvert    <= w_ainvert_nxt;
            r_bnegate    <= w_bnegate_nxt;
            r_op         <= w_op_nxt;
            r_req_ready  <= w_req_ready_nxt;
            r_rsp_valid  <= w_rsp_valid_nxt;
            r_rsp_result <= w_rsp_result_nxt;
            r_rsp_ovf    <= w_rsp_ovf_nxt;
            r_rsp_zero   <= w_rsp_zero_nxt;
            r_rsp_err    <= w_rsp_err_nxt;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        w_state_nxt      = r_state;
        w_cnt_nxt        = r_cnt;
        w_funct_nxt      = r_funct;
        w_alu_in1_nxt    = r_alu_in1;
        w_alu_in2_nxt    = r_alu_in2;
        w_ainvert_nxt    = r_ainvert;
        w_bnegate_nxt    = r_bnegate;
        w_op_nxt         = r_op;
        w_rsp_valid_nxt  = r_rsp_valid;
        w_rsp_result_nxt = r_rsp_result;
        w_rsp_ovf_nxt    = r_rsp_ovf;
        w_rsp_zero_nxt   = r_rsp_zero;
        w_rsp_err_nxt    = r_rsp_err;

        case (r_state)
            S_IDLE: begin
                if (req_valid) begin
                    w_funct_nxt = req_funct;
                    if (w_req_legal) begin
                        // ALU registers double as the captured operands
                        w_state_nxt   = S_EXEC;
                        w_cnt_nxt     = CNT_LOAD;
                        w_alu_in1_nxt = req_a;
                        w_alu_in2_nxt = req_b;
                        w_ainvert_nxt = req_funct[3];
                        w_bnegate_nxt = req_funct[2];
                        w_op_nxt      = req_funct[1:0];
                    end else begin
                        // Illegal code: answer immediately, never touch the ALU
                        w_state_nxt      = S_RESP;
                        w_rsp_valid_nxt  = 1'b1;
                        w_rsp_result_nxt = '0;
                        w_rsp_ovf_nxt    = 1'b0;
                        w_rsp_zero_nxt   = 1'b0;
                        w_rsp_err_nxt    = 1'b1;
                    end
                end
            end

            S_EXEC: begin
                if (r_cnt == '0) begin
                    w_state_nxt      = S_RESP;
                    w_rsp_valid_nxt  = 1'b1;
                    w_rsp_zero_nxt   = alu_zero;
                    w_rsp_ovf_nxt    = w_ovf;
`ifdef ALU_SEQ_OVF_TRAP_EN
                    w_rsp_result_nxt = w_ovf ? '0 : alu_result;
                    w_rsp_err_nxt    = w_ovf;
`else
                    w_rsp_result_nxt = alu_result;
                    w_rsp_err_nxt    = 1'b0;
`endif
                    w_cnt_nxt        = '0;
                    w_alu_in1_nxt    = '0;
                    w_alu_in2_nxt    = '0;
                    w_ainvert_nxt    = 1'b0;
                    w_bnegate_nxt    = 1'b0;
                    w_op_nxt         = '0;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end

            S_RESP: begin
                if (rsp_ready) begin
                    w_state_nxt      = S_IDLE;
                    w_rsp_valid_nxt  = 1'b0;
                    w_rsp_result_nxt = '0;
                    w_rsp_ovf_nxt    = 1'b0;
                    w_rsp_zero_nxt   = 1'b0;
                    w_rsp_err_nxt    = 1'b0;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        w_req_ready_nxt = (w_state_nxt == S_IDLE);
    end

    assign req_ready    = r_req_ready;
    assign alu_in1      = r_alu_in1;
    assign alu_in2      = r_alu_in2;
    assign alu_ainvert  = r_ainvert;
    assign alu_bnegate  = r_bnegate;
    assign alu_op       = r_op;
    assign rsp_valid    = r_rsp_valid;
    assign rsp_result   = r_rsp_result;
    assign rsp_overflow = r_rsp_ovf;
    assign rsp_zero     = r_rsp_zero;
    assign rsp_err      = r_rsp_err;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer
// Purpose: randomized self-checking bench for alu_op_sequencer (WIDTH=32,
// SETTLE=2) with a behavioural ALU attached and an operation-level model.
module tb_alu_op_sequencer;

    localparam int unsigned W  = 32;
    localparam int unsigned ST = 2;

    logic          clk;
    logic          rst_n;
    logic          req_valid;
    logic          req_ready;
    logic [3:0]    req_funct;
    logic [W-1:0]  req_a, req_b;
    logic [W-1:0]  alu_in1, alu_in2;
    logic          alu_ainvert, alu_bnegate;
    logic [1:0]    alu_op;
    logic [W-1:0]  alu_result;
    logic          alu_overflow, alu_zero;
    logic          rsp_valid, rsp_ready;
    logic [W-1:0]  rsp_result;
    logic          rsp_overflow, rsp_zero, rsp_err;

    int n_total = 0;
    int n_bad   = 0;

    alu_op_sequencer #(.WIDTH(W), .SETTLE(ST)) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_funct    (req_funct),
        .req_a        (req_a),
        .req_b        (req_b),
        .alu_in1      (alu_in1),
        .alu_in2      (alu_in2),
        .alu_ainvert  (alu_ainvert),
        .alu_bnegate  (alu_bnegate),
        .alu_op       (alu_op),
        .alu_result   (alu_result),
        .alu_overflow (alu_overflow),
        .alu_zero     (alu_zero),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_result   (rsp_result),
        .rsp_overflow (rsp_overflow),
        .rsp_zero     (rsp_zero),
        .rsp_err      (rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural MIPS-style ALU: invert/negate then AND/OR/ADD/SLT
    logic [W-1:0] w_a, w_b;
    logic [W:0]   w_sum;
    logic         w_ovf;
    always_comb begin
        w_a   = alu_ainvert ? ~alu_in1 : alu_in1;
        w_b   = alu_bnegate ? ~alu_in2 : alu_in2;
        w_sum = {1'b0, w_a} + {1'b0, w_b} + (W+1)'(alu_bnegate);
        w_ovf = (w_a[W-1] == w_b[W-1]) && (w_sum[W-1] != w_a[W-1]);
        case (alu_op)
            2'd0:    alu_result = w_a & w_b;
            2'd1:    alu_result = w_a | w_b;
            2'd2:    alu_result = w_sum[W-1:0];
            default: alu_result = {{(W-1){1'b0}}, w_sum[W-1] ^ w_ovf};
        endcase
        alu_overflow = w_ovf;
        alu_zero     = (alu_result == '0);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Operation-level reference for one request
    task automatic model(input logic [3:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] r, output logic ovf, output logic zero,
                         output logic err, output logic legal);
        ovf = 1'b0; err = 1'b0; legal = 1'b1; r = '0;
        case (f)
            4'b0000: r = a & b;
            4'b0001: r = a | b;
            4'b0010: begin
                r   = a + b;
                ovf = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
            end
            4'b0110: begin
                r   = a - b;
                ovf = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
            end
            4'b0111: r = ($signed(a) < $signed(b)) ? W'(1) : W'(0);
            4'b1100: r = ~(a | b);
            default: begin
                legal = 1'b0;
                err   = 1'b1;
            end
        endcase
        zero = legal && (r == '0);
`ifdef ALU_SEQ_OVF_TRAP_EN
        if (ovf) begin
            r   = '0;
            err = 1'b1;
        end
`endif
    endtask

    task automatic junk_req();
        req_valid = 1'($urandom);
        req_funct = 4'($urandom);
        req_a     = $urandom;
        req_b     = $urandom;
    endtask

    task automatic check_alu_idle(input string tag);
        check(tag, 64'({alu_in1, alu_in2, alu_ainvert, alu_bnegate, alu_op}), 64'(0));
    endtask

    // One full transaction; entered and left at #1 after an edge, in IDLE
    task automatic run_txn(input logic [3:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                           input int hold);
        logic [W-1:0] er;
        logic eo, ez, ee, el;
        model(f, a, b, er, eo, ez, ee, el);
        req_valid = 1'b1; req_funct = f; req_a = a; req_b = b;
        rsp_ready = 1'($urandom);
        @(posedge clk); #1;
        check("accept_ready", 64'(req_ready), 64'(0));
        if (el) begin
            for (int k = 0; k < int'(ST); k++) begin
                check("exec_rsp_valid", 64'(rsp_valid), 64'(0));
                check("exec_in1", 64'(alu_in1), 64'(a));
                check("exec_in2", 64'(alu_in2), 64'(b));
                check("exec_ctrl", 64'({alu_ainvert, alu_bnegate, alu_op}), 64'(f));
                junk_req();
                rsp_ready = 1'($urandom);
                @(posedge clk); #1;
            end
        end
        for (int h = 0; h <= hold; h++) begin
            check("rsp_valid", 64'(rsp_valid), 64'(1));
            check("rsp_result", 64'(rsp_result), 64'(er));
            check("rsp_flags", 64'({rsp_overflow, rsp_zero, rsp_err}), 64'({eo, ez, ee}));
            check("rsp_req_ready", 64'(req_ready), 64'(0));
            check_alu_idle("rsp_alu_zero");
            junk_req();
            rsp_ready = (h == hold);
            if (h == hold) req_valid = 1'b1;
            @(posedge clk); #1;
        end
        check("consume_valid", 64'(rsp_valid), 64'(0));
        check("consume_ready", 64'(req_ready), 64'(1));
        req_valid = 1'b0;
        rsp_ready = 1'b0;
    endtask

    logic [3:0]   legal_f [6] = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100};
    logic [W-1:0] special [5] = '{32'h0, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 32'h1};

    function automatic logic [W-1:0] pick_op();
        if ($urandom_range(0, 3) == 0) return special[$urandom_range(0, 4)];
        return $urandom;
    endfunction

    initial begin
        logic [3:0]   f;
        logic [W-1:0] a, b;
        rst_n = 1'b0; req_valid = 1'b0; req_funct = '0; req_a = '0; req_b = '0;
        rsp_ready = 1'b0;
        #12;
        check("rst_req_ready", 64'(req_ready), 64'(1));
        check("rst_rsp", 64'({rsp_valid, rsp_result, rsp_overflow, rsp_zero, rsp_err}), 64'(0));
        check_alu_idle("rst_alu");
        #10 rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_ready", 64'(req_ready), 64'(1));
        check("post_rst_valid", 64'(rsp_valid), 64'(0));

        run_txn(4'b0010, 32'h0000_0005, 32'h0000_0003, 0);
        run_txn(4'b0110, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 1);
        run_txn(4'b0111, 32'hFFFF_FFFF, 32'h0000_0001, 0);
        run_txn(4'b0110, 32'h0000_1234, 32'h0000_1234, 2);
        run_txn(4'b1111, 32'hDEAD_BEEF, 32'h1234_5678, 1);
        run_txn(4'b1100, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 5);
        run_txn(4'b0010, 32'h7FFF_FFFF, 32'h0000_0001, 0);

        // Asynchronous reset in the middle of EXEC
        req_valid = 1'b1; req_funct = 4'b0001; req_a = 32'h00FF_00FF; req_b = 32'h0F0F_0F0F;
        @(posedge clk); #1;
        check("mid_exec_in1", 64'(alu_in1), 64'(32'h00FF_00FF));
        req_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_alu_in", 64'({alu_in1, alu_in2}), 64'(0));
        check("async_rst_ctrl", 64'({alu_ainvert, alu_bnegate, alu_op}), 64'(0));
        check("async_rst_rsp", 64'({rsp_valid, rsp_result, rsp_overflow, rsp_zero, rsp_err}), 64'(0));
        check("async_rst_ready", 64'(req_ready), 64'(1));
        @(posedge clk); #3 rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            rsp_ready = 1'($urandom);
            @(posedge clk); #1;
            check("abort_no_rsp", 64'(rsp_valid), 64'(0));
            check("abort_ready", 64'(req_ready), 64'(1));
        end
        rsp_ready = 1'b0;

        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 3) == 0) f = 4'($urandom);
            else                           f = legal_f[$urandom_range(0, 5)];
            a = pick_op();
            b = ($urandom_range(0, 7) == 0) ? a : pick_op();
            run_txn(f, a, b, int'($urandom_range(0, 3)));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
